// File: rtl/timer_display_mux_if.sv
// Digit/control inputs and multiplexed display outputs of the timer display stage.
// master drives digits and controls; slave is the display multiplexer.
interface timer_display_mux_if;
   logic [3:0] min_upper;
   logic [3:0] min_lower;
   logic [3:0] sec_upper;
   logic [3:0] sec_lower;
   logic       load;
   logic       blank_lz;
   logic       done;
   logic [6:0] seg;
   logic [3:0] AN;
   logic       frame_tick;

   modport master (
      output min_upper, min_lower, sec_upper, sec_lower, load, blank_lz, done,
      input  seg, AN, frame_tick
   );

   modport slave (
      input  min_upper, min_lower, sec_upper, sec_lower, load, blank_lz, done,
      output seg, AN, frame_tick
   );
endinterface

// File: rtl/timer_display_mux.sv
// Time-multiplexes four BCD digits (MM:SS) onto a common-anode 7-segment display.
// Outputs registered one cycle after scan/display state; no backpressure, digits latched per frame.
module timer_display_mux #(
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 2,
   parameter int BLINK_HALF  = 25000000,
   parameter int CNT_W       = 26
) (
   input  logic                CLK,
   input  logic                reset,
   timer_display_mux_if.slave  bus
);

   localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_HALF - 1);
   localparam logic [CNT_W-1:0] GUARD_CNT    = CNT_W'(GUARD);
   localparam logic [6:0]       SEG_OFF      = 7'b1111111;
   localparam logic [3:0]       AN_OFF       = 4'b1111;

   logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_on_q, blink_on_d;
   // Digit index matches anode index: [0]=sec_lower ... [3]=min_upper.
   logic [3:0][3:0]  pend_q, pend_d;
   logic [3:0][3:0]  disp_q, disp_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;
   logic             frame_tick_q, frame_tick_d;

   logic             slot_tick;
   logic             frame_wrap;
   logic [3:0]       cur_digit;
   logic             slot_off;

   function automatic logic [6:0] seg_decode(input logic [3:0] val);
      logic [6:0] s;
      case (val)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_comb begin
      refresh_cnt_d = refresh_cnt_q;
      idx_d         = idx_q;
      blink_cnt_d   = blink_cnt_q;
      blink_on_d    = blink_on_q;
      pend_d        = pend_q;
      disp_d        = disp_q;
      frame_tick_d  = 1'b0;
      seg_d         = SEG_OFF;
      an_d          = AN_OFF;

      slot_tick  = (refresh_cnt_q == REFRESH_LAST);
      frame_wrap = slot_tick && (idx_q == 2'd3);

      // Scan runs free; only reset restarts it.
      if (slot_tick) begin
         refresh_cnt_d = '0;
         idx_d         = idx_q + 2'd1;
      end else begin
         refresh_cnt_d = refresh_cnt_q + 1'b1;
      end

      if (bus.load) begin
         pend_d = {bus.min_upper, bus.min_lower, bus.sec_upper, bus.sec_lower};
      end

      // Display copies the pending digits only at the frame boundary, so a
      // load landing on the wrap cycle is shown one frame later.
      if (frame_wrap) begin
         disp_d       = pend_q;
         frame_tick_d = 1'b1;
      end

      if (!bus.done) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end

      cur_digit = disp_q[idx_q];
      // done low overrides the blink phase so the display returns without waiting a flop.
      slot_off  = (refresh_cnt_q < GUARD_CNT)
               || (bus.done && !blink_on_q)
               || ((idx_q == 2'd3) && bus.blank_lz && (cur_digit == 4'd0));

      if (!slot_off) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = seg_decode(cur_digit);
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         refresh_cnt_q <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_on_q    <= 1'b1;
         pend_q        <= '0;
         disp_q        <= '0;
         seg_q         <= SEG_OFF;
         an_q          <= AN_OFF;
         frame_tick_q  <= 1'b0;
      end else begin
         refresh_cnt_q <= refresh_cnt_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_on_q    <= blink_on_d;
         pend_q        <= pend_d;
         disp_q        <= disp_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         frame_tick_q  <= frame_tick_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.AN         = an_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_timer_display_mux.sv
// Directed bench for timer_display_mux with REFRESH_DIV=4, GUARD=1, BLINK_HALF=8.
// cyc counts edges after reset release; one frame spans 16 cycles.
module tb_timer_display_mux;

   localparam logic [6:0] S0   = 7'b1000000;
   localparam logic [6:0] S1   = 7'b1111001;
   localparam logic [6:0] S2   = 7'b0100100;
   localparam logic [6:0] S3   = 7'b0110000;
   localparam logic [6:0] S4   = 7'b0011001;
   localparam logic [6:0] S5   = 7'b0010010;
   localparam logic [6:0] S6   = 7'b0000010;
   localparam logic [6:0] S7   = 7'b1111000;
   localparam logic [6:0] S8   = 7'b0000000;
   localparam logic [6:0] S9   = 7'b0010000;
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] SOFF = 7'b1111111;

   logic CLK;
   logic reset;
   int   cyc;
   int   n_chk;
   int   n_err;

   timer_display_mux_if dbus ();

   timer_display_mux #(
      .REFRESH_DIV (4),
      .GUARD       (1),
      .BLINK_HALF  (8),
      .CNT_W       (26)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (dbus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] seg);
      chk({tag, ".AN"}, 32'(dbus.AN), 32'(an));
      chk({tag, ".seg"}, 32'(dbus.seg), 32'(seg));
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic set_digits(input logic [3:0] mu, input logic [3:0] ml,
                             input logic [3:0] su, input logic [3:0] sl);
      dbus.min_upper = mu;
      dbus.min_lower = ml;
      dbus.sec_upper = su;
      dbus.sec_lower = sl;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      cyc   = 0;
      reset = 1'b1;
      set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      dbus.load     = 1'b0;
      dbus.blank_lz = 1'b0;
      dbus.done     = 1'b0;
      repeat (3) tick();
      cyc   = 0;
      reset = 1'b0;

      // Reset state, then load 12:34
      chk_out("reset", 4'b1111, SOFF);
      chk("reset.frame_tick", 32'(dbus.frame_tick), 32'd0);
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      dbus.load = 1'b1;
      tick();
      dbus.load = 1'b0;

      step_to(16); chk("ft_first", 32'(dbus.frame_tick), 32'd1);
      step_to(17); chk("ft_one_cycle", 32'(dbus.frame_tick), 32'd0);
                   chk_out("guard0", 4'b1111, SOFF);
      step_to(18); chk_out("slot0_4", 4'b1110, S4);
      step_to(20); chk_out("slot0_4_end", 4'b1110, S4);
      step_to(21); chk_out("guard1", 4'b1111, SOFF);
      step_to(22); chk_out("slot1_3", 4'b1101, S3);
      step_to(26); chk_out("slot2_2", 4'b1011, S2);
      step_to(30); chk_out("slot3_1", 4'b0111, S1);
      step_to(31); chk("ft_quiet", 32'(dbus.frame_tick), 32'd0);
      step_to(32); chk("ft_second", 32'(dbus.frame_tick), 32'd1);

      // 05:09 with leading-zero blanking
      step_to(33);
      set_digits(4'd0, 4'd5, 4'd0, 4'd9);
      dbus.blank_lz = 1'b1;
      dbus.load     = 1'b1;
      tick();
      dbus.load = 1'b0;
      step_to(50); chk_out("lz_slot0_9", 4'b1110, S9);
      step_to(54); chk_out("lz_slot1_0", 4'b1101, S0);
      step_to(58); chk_out("lz_slot2_5", 4'b1011, S5);
      step_to(62); chk_out("lz_slot3_blank", 4'b1111, SOFF);
      step_to(64); chk_out("lz_slot3_blank_end", 4'b1111, SOFF);
      step_to(66); dbus.blank_lz = 1'b0;
      step_to(78); chk_out("nolz_slot3_0", 4'b0111, S0);

      // Invalid digit shows a dash
      step_to(81);
      set_digits(4'd1, 4'd2, 4'd3, 4'hC);
      dbus.load = 1'b1;
      tick();
      dbus.load = 1'b0;
      step_to(98);  chk_out("dash_slot0", 4'b1110, DASH);
      step_to(102); chk_out("dash_slot1_3", 4'b1101, S3);
      step_to(106); chk_out("dash_slot2_2", 4'b1011, S2);
      step_to(110); chk_out("dash_slot3_1", 4'b0111, S1);

      // Load on the exact wrap cycle: old digits persist one more frame
      step_to(111);
      set_digits(4'd5, 4'd6, 4'd7, 4'd8);
      dbus.load = 1'b1;
      tick();
      dbus.load = 1'b0;
      step_to(114); chk_out("race_old_slot0", 4'b1110, DASH);
      step_to(126); chk_out("race_old_slot3", 4'b0111, S1);
      step_to(128); chk("race_ft", 32'(dbus.frame_tick), 32'd1);
      step_to(130); chk_out("race_new_slot0", 4'b1110, S8);
      step_to(134); chk_out("race_new_slot1", 4'b1101, S7);
      step_to(138); chk_out("race_new_slot2", 4'b1011, S6);
      step_to(142); chk_out("race_new_slot3", 4'b0111, S5);

      // Blink: 8 cycles visible, 8 cycles dark
      step_to(143); dbus.done = 1'b1;
      step_to(150); chk_out("blink_on_a", 4'b1101, S7);
      step_to(154); chk_out("blink_off_a", 4'b1111, SOFF);
      step_to(158); chk_out("blink_off_b", 4'b1111, SOFF);
      step_to(162); chk_out("blink_on_b", 4'b1110, S8);
      step_to(166); chk_out("blink_on_c", 4'b1101, S7);
      step_to(170); chk_out("blink_off_c", 4'b1111, SOFF);
      dbus.done = 1'b0;
      step_to(171); chk_out("done_drop_vis", 4'b1011, S6);
      step_to(172); chk_out("done_drop_vis2", 4'b1011, S6);

      // Reset mid-slot discards pending and displayed digits
      set_digits(4'd9, 4'd9, 4'd9, 4'd9);
      dbus.load = 1'b1;
      tick();
      dbus.load = 1'b0;
      step_to(181); reset = 1'b1;
      step_to(182); reset = 1'b0;
      chk_out("midreset", 4'b1111, SOFF);
      chk("midreset.frame_tick", 32'(dbus.frame_tick), 32'd0);
      step_to(188); chk_out("post_reset_slot1_0", 4'b1101, S0);
      step_to(198); chk("post_reset_ft", 32'(dbus.frame_tick), 32'd1);
      step_to(200); chk_out("post_reset_slot0_0", 4'b1110, S0);
      step_to(212); chk_out("post_reset_slot3_0", 4'b0111, S0);

      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
